// File: rtl/cmp_int_serial.sv
// Digit-serial integer comparator: DIGIT bits per cycle through a borrow chain, LSB chunk first.
// Signed/unsigned select, six compare modes, valid/ready on both request and result sides.
module cmp_int_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             borrow, eq;
  logic [2:0]       op_q;
  logic             sgn_q;
  logic [DIGIT-1:0] msk, ac, bc;
  logic             last, accept, ohs, bnx, lt, gt, y_nx;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign ohs      = out_valid & out_ready;
  assign last     = (cnt == CW'(NCHUNK - 1));

  // Signed order: flip the sign bit of both operands, which lives in the top bit of the last chunk.
  always_comb begin
    msk          = '0;
    msk[DIGIT-1] = sgn_q & last;
  end

  assign ac  = a_sr[DIGIT-1:0] ^ msk;
  assign bc  = b_sr[DIGIT-1:0] ^ msk;
  // Borrow out of ac - bc - borrow without materialising the difference.
  assign bnx = (ac < bc) | ((ac == bc) & borrow);

  assign lt = borrow;
  assign gt = ~lt & ~eq;

  always_comb begin
    y_nx = 1'b0;
    case (op_q)
      3'd0:    y_nx = gt;
      3'd1:    y_nx = ~lt;
      3'd2:    y_nx = lt;
      3'd3:    y_nx = ~gt;
      3'd4:    y_nx = eq;
      3'd5:    y_nx = ~eq;
      default: y_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last)   state_nx = DONE;
      DONE:    if (ohs)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      cnt       <= '0;
      borrow    <= 1'b0;
      eq        <= 1'b0;
      op_q      <= '0;
      sgn_q     <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_sr   <= in_a;
          b_sr   <= in_b;
          op_q   <= in_op;
          sgn_q  <= in_signed;
          borrow <= 1'b0;
          eq     <= 1'b1;
          cnt    <= '0;
        end
        RUN: begin
          borrow <= bnx;
          eq     <= eq & (ac == bc);
          a_sr   <= WIDTH'({{DIGIT{1'b0}}, a_sr} >> DIGIT);
          b_sr   <= WIDTH'({{DIGIT{1'b0}}, b_sr} >> DIGIT);
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          // First DONE cycle registers the result from the settled borrow/eq.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_y     <= y_nx;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
